// File: rtl/ddr3_cmd_arbiter.sv
// ddr3_cmd_arbiter: shares one MCB command port between two DDR3 requesters.
// Each requester owns a one-entry holding register; selection is round-robin,
// and a requester may lock the port for up to MAX_LOCK back-to-back commands.
// Optional periodic refresh injection is enabled by defining DDR3_ARB_REFRESH_EN.
//
// Handshake: a strobe on req_cmd_en[i] is accepted at a rising edge when
// req_cmd_full[i] is low at that edge; a strobe while full is dropped and
// sets the sticky req_overflow[i]. Toward the MCB, cmd_en is a one-cycle
// registered strobe raised only when cmd_full was low in the deciding cycle,
// with cmd_instr/cmd_bl/cmd_word_addr valid in the same cycle.
module ddr3_cmd_arbiter #(
  parameter int unsigned MAX_LOCK       = 16,
  parameter logic [15:0] REFRESH_PERIOD = 16'd1560
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_cmd_en,
  input  logic [2:0]  req_cmd_instr0,
  input  logic [2:0]  req_cmd_instr1,
  input  logic [5:0]  req_cmd_bl0,
  input  logic [5:0]  req_cmd_bl1,
  input  logic [27:0] req_cmd_addr0,
  input  logic [27:0] req_cmd_addr1,
  input  logic [1:0]  req_lock,
  output logic [1:0]  req_cmd_full,
  output logic [1:0]  req_overflow,
  output logic [1:0]  grant,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [27:0] cmd_word_addr,
  input  logic        cmd_full,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  localparam logic [7:0] MAX_LOCK_8 = 8'(MAX_LOCK);
  localparam logic       LOCK_EN    = (MAX_LOCK > 32'd1);

  state_t      state_q, state_d;
  logic [1:0]  p_valid;
  logic [2:0]  h_instr [2];
  logic [5:0]  h_bl    [2];
  logic [27:0] h_addr  [2];
  logic [2:0]  in_instr [2];
  logic [5:0]  in_bl    [2];
  logic [27:0] in_addr  [2];

  logic        last_q;
  logic        owner_q, owner_d;
  logic [7:0]  hold_cnt_q, hold_inc;
  logic        hold_load, hold_step;
  logic        rr_sel;
  logic        issue_req, issue_sel, issue_ref;
  logic        refresh_pend;

  assign in_instr[0] = req_cmd_instr0;
  assign in_instr[1] = req_cmd_instr1;
  assign in_bl[0]    = req_cmd_bl0;
  assign in_bl[1]    = req_cmd_bl1;
  assign in_addr[0]  = req_cmd_addr0;
  assign in_addr[1]  = req_cmd_addr1;

  // Round-robin choice: with both pending, the one not served last wins.
  assign rr_sel   = (p_valid == 2'b11) ? ~last_q : p_valid[1];
  assign hold_inc = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;

  assign req_cmd_full = p_valid;
  assign grant        = (state_q == ST_LOCKED) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign dbg_state    = state_q;

  // Next-state and issue decision.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    issue_req = 1'b0;
    issue_sel = rr_sel;
    issue_ref = 1'b0;
    hold_load = 1'b0;
    hold_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (refresh_pend) begin
          state_d = ST_REFRESH;
        end else if ((|p_valid) && !cmd_full) begin
          issue_req = 1'b1;
          issue_sel = rr_sel;
          owner_d   = rr_sel;
          hold_load = 1'b1;
          if (req_lock[rr_sel] && LOCK_EN) state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        issue_sel = owner_q;
        if (refresh_pend) begin
          state_d = ST_REFRESH;
        end else if (p_valid[owner_q] && !cmd_full) begin
          issue_req = 1'b1;
          hold_step = 1'b1;
          if (hold_inc == MAX_LOCK_8) state_d = ST_IDLE;
        end else if (!req_lock[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
`ifdef DDR3_ARB_REFRESH_EN
      ST_REFRESH: begin
        if (!cmd_full) begin
          issue_ref = 1'b1;
          state_d   = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, ownership, round-robin pointer and lock run length.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b0;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (issue_req) last_q <= issue_sel;
      if (hold_load) hold_cnt_q <= 8'd1;
      else if (hold_step) hold_cnt_q <= hold_inc;
    end
  end

  // Holding registers: capture when empty, flag overflow when a strobe hits a full entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_valid      <= 2'b00;
      req_overflow <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        h_instr[i] <= 3'd0;
        h_bl[i]    <= 6'd0;
        h_addr[i]  <= 28'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_cmd_en[i]) begin
          if (p_valid[i]) begin
            req_overflow[i] <= 1'b1;
          end else begin
            p_valid[i] <= 1'b1;
            h_instr[i] <= in_instr[i];
            h_bl[i]    <= in_bl[i];
            h_addr[i]  <= in_addr[i];
          end
        end
        if (issue_req && (issue_sel == 1'(i))) p_valid[i] <= 1'b0;
      end
    end
  end

  // Registered MCB command port; fields hold their last value between issues.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_en        <= 1'b0;
      cmd_instr     <= 3'd0;
      cmd_bl        <= 6'd0;
      cmd_word_addr <= 28'd0;
    end else begin
      cmd_en <= issue_req | issue_ref;
      if (issue_ref) begin
        cmd_instr     <= 3'b100;
        cmd_bl        <= 6'd0;
        cmd_word_addr <= 28'd0;
      end else if (issue_req) begin
        cmd_instr     <= h_instr[issue_sel];
        cmd_bl        <= h_bl[issue_sel];
        cmd_word_addr <= h_addr[issue_sel];
      end
    end
  end

`ifdef DDR3_ARB_REFRESH_EN
  logic [15:0] refresh_cnt_q;
  logic        refresh_pend_q;

  // Free-running refresh timer; an expiry while already pending is absorbed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_cnt_q  <= 16'd0;
      refresh_pend_q <= 1'b0;
    end else if (refresh_cnt_q == REFRESH_PERIOD - 16'd1) begin
      refresh_cnt_q  <= 16'd0;
      refresh_pend_q <= 1'b1;
    end else begin
      refresh_cnt_q <= refresh_cnt_q + 16'd1;
      if (issue_ref) refresh_pend_q <= 1'b0;
    end
  end

  assign refresh_pend = refresh_pend_q;
`else
  logic unused_refresh_period;
  assign refresh_pend          = 1'b0;
  assign unused_refresh_period = ^REFRESH_PERIOD;
`endif

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// tb_ddr3_cmd_arbiter: directed and randomized checks of ddr3_cmd_arbiter
// against a cycle-level behavioural model of the arbitration rules.
module tb_ddr3_cmd_arbiter;

  localparam int TB_MAX_LOCK = 4;
`ifdef DDR3_ARB_REFRESH_EN
  localparam int TB_REF = 100;
`else
  localparam int TB_REF = 1560;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_cmd_en = 2'b00;
  logic [2:0]  req_cmd_instr0 = 3'd0, req_cmd_instr1 = 3'd0;
  logic [5:0]  req_cmd_bl0 = 6'd0, req_cmd_bl1 = 6'd0;
  logic [27:0] req_cmd_addr0 = 28'd0, req_cmd_addr1 = 28'd0;
  logic [1:0]  req_lock = 2'b00;
  logic        cmd_full = 1'b0;
  logic [1:0]  req_cmd_full, req_overflow, grant;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [27:0] cmd_word_addr;
  logic [1:0]  dbg_state_unused;

  ddr3_cmd_arbiter #(.MAX_LOCK(TB_MAX_LOCK), .REFRESH_PERIOD(16'(TB_REF))) dut (
    .clk(clk), .rst(rst),
    .req_cmd_en(req_cmd_en),
    .req_cmd_instr0(req_cmd_instr0), .req_cmd_instr1(req_cmd_instr1),
    .req_cmd_bl0(req_cmd_bl0), .req_cmd_bl1(req_cmd_bl1),
    .req_cmd_addr0(req_cmd_addr0), .req_cmd_addr1(req_cmd_addr1),
    .req_lock(req_lock),
    .req_cmd_full(req_cmd_full), .req_overflow(req_overflow), .grant(grant),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_word_addr(cmd_word_addr), .cmd_full(cmd_full),
    .dbg_state(dbg_state_unused)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = free arbitration, 1 = port held by m_owner, 2 = refresh owed
  bit [1:0]    m_pv = 2'b00;
  bit [1:0]    m_ovf = 2'b00;
  logic [2:0]  m_ins [2];
  logic [5:0]  m_bl  [2];
  logic [27:0] m_adr [2];
  int          m_last = 0, m_mode = 0, m_owner = 0, m_run = 0, m_rcnt = 0;
  bit          m_rpend = 1'b0;
  bit          m_en = 1'b0;
  logic [2:0]  m_ci;
  logic [5:0]  m_cb;
  logic [27:0] m_ca;
  logic [36:0] exp_q[$];

  always @(posedge clk) begin
    int who;
    if (!rst) begin
      m_pv = 2'b00; m_ovf = 2'b00; m_last = 0; m_mode = 0; m_owner = 0;
      m_run = 0; m_rcnt = 0; m_rpend = 1'b0; m_en = 1'b0;
      exp_q.delete();
    end else begin
      who = -1;
      if (m_mode == 0) begin
        if (m_rpend) m_mode = 2;
        else if (m_pv != 2'b00 && !cmd_full) begin
          who = (m_pv == 2'b11) ? 1 - m_last : (m_pv[1] ? 1 : 0);
          m_run = 1;
          if (req_lock[who] && TB_MAX_LOCK > 1) begin m_mode = 1; m_owner = who; end
        end
      end else if (m_mode == 1) begin
        if (m_rpend) m_mode = 2;
        else if (m_pv[m_owner] && !cmd_full) begin
          who = m_owner;
          m_run++;
          if (m_run == TB_MAX_LOCK) m_mode = 0;
        end else if (!req_lock[m_owner]) m_mode = 0;
      end else begin
        if (!cmd_full) begin who = 2; m_rpend = 1'b0; m_mode = 0; end
      end
      m_en = (who >= 0);
      if (who == 2) begin
        m_ci = 3'b100; m_cb = 6'd0; m_ca = 28'd0;
      end else if (who >= 0) begin
        m_ci = m_ins[who]; m_cb = m_bl[who]; m_ca = m_adr[who];
        m_last = who;
        m_pv[who] = 1'b0;
      end
      if (who >= 0) exp_q.push_back({m_ci, m_cb, m_ca});
      // strobes use the pre-edge occupancy: a full entry drops the strobe
      for (int i = 0; i < 2; i++) begin
        if (req_cmd_en[i]) begin
          if (m_pv[i] || (who == i)) m_ovf[i] = 1'b1;
          else begin
            m_pv[i]  = 1'b1;
            m_ins[i] = (i == 0) ? req_cmd_instr0 : req_cmd_instr1;
            m_bl[i]  = (i == 0) ? req_cmd_bl0 : req_cmd_bl1;
            m_adr[i] = (i == 0) ? req_cmd_addr0 : req_cmd_addr1;
          end
        end
      end
`ifdef DDR3_ARB_REFRESH_EN
      if (m_rcnt == TB_REF - 1) begin m_rcnt = 0; m_rpend = 1'b1; end
      else m_rcnt++;
`endif
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [36:0] e;
    check("cmd_en", 64'(cmd_en), 64'(m_en));
    check("req_cmd_full", 64'(req_cmd_full), 64'(m_pv));
    check("req_overflow", 64'(req_overflow), 64'(m_ovf));
    check("grant", 64'(grant), 64'((m_mode == 1) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00));
    if (m_en) begin
      if (exp_q.size() == 0) begin
        check("exp_q_nonempty", 64'(0), 64'(1));
      end else begin
        e = exp_q.pop_front();
        check("cmd_fields", 64'({cmd_instr, cmd_bl, cmd_word_addr}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_cmd_en = 2'b00; req_lock = 2'b00; cmd_full = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    req_cmd_en = 2'b00; req_lock = 2'b00; cmd_full = 1'b0;
    repeat (n) step();
  endtask

  int  n0, nb, ref_at;
  bit  seen1;

  initial begin
    // reset values
    rst = 1'b0;
    step();
    step();
    check("rst_cmd_en", 64'(cmd_en), 64'(1'b0));
    check("rst_cmd_fields", 64'({cmd_instr, cmd_bl, cmd_word_addr}), 64'(0));
    check("rst_full", 64'(req_cmd_full), 64'(2'b00));
    check("rst_ovf", 64'(req_overflow), 64'(2'b00));
    check("rst_grant", 64'(grant), 64'(2'b00));
    rst = 1'b1;

    // single command: 2-cycle latency, full for exactly one cycle
    req_cmd_instr0 = 3'b010; req_cmd_bl0 = 6'd63; req_cmd_addr0 = 28'h0000100;
    req_cmd_en = 2'b01;
    step();
    req_cmd_en = 2'b00;
    check("t1_full_captured", 64'(req_cmd_full), 64'(2'b01));
    check("t1_no_early_en", 64'(cmd_en), 64'(1'b0));
    step();
    check("t1_cmd_en", 64'(cmd_en), 64'(1'b1));
    check("t1_instr", 64'(cmd_instr), 64'(3'b010));
    check("t1_bl", 64'(cmd_bl), 64'(6'd63));
    check("t1_addr", 64'(cmd_word_addr), 64'(28'h0000100));
    check("t1_full_cleared", 64'(req_cmd_full), 64'(2'b00));
    step();
    check("t1_en_one_cycle", 64'(cmd_en), 64'(1'b0));

    // fairness: simultaneous strobes after reset, requester 1 first
    do_reset();
    req_cmd_instr0 = 3'b001; req_cmd_bl0 = 6'd1; req_cmd_addr0 = 28'h00000A0;
    req_cmd_instr1 = 3'b011; req_cmd_bl1 = 6'd2; req_cmd_addr1 = 28'h00000B1;
    req_cmd_en = 2'b11;
    step();
    req_cmd_en = 2'b00;
    check("t2_both_full", 64'(req_cmd_full), 64'(2'b11));
    step();
    check("t2_first_en", 64'(cmd_en), 64'(1'b1));
    check("t2_first_is_r1", 64'(cmd_word_addr), 64'(28'h00000B1));
    step();
    check("t2_second_en", 64'(cmd_en), 64'(1'b1));
    check("t2_second_is_r0", 64'(cmd_word_addr), 64'(28'h00000A0));
    step();
    check("t2_done", 64'(cmd_en), 64'(1'b0));

    // lock bound: MAX_LOCK commands from locked requester 0, then requester 1
    do_reset();
    req_cmd_instr0 = 3'b000; req_cmd_bl0 = 6'd7; req_cmd_addr0 = 28'h10;
    req_cmd_instr1 = 3'b001; req_cmd_bl1 = 6'd5; req_cmd_addr1 = 28'hAAA;
    req_lock = 2'b01;
    req_cmd_en = 2'b01;
    step();
    req_cmd_en = 2'b10;
    step();
    req_cmd_en = 2'b00;
    n0 = 0; seen1 = 1'b0;
    for (int c = 0; c < 60 && !seen1; c++) begin
      if (cmd_en) begin
        if (cmd_word_addr == 28'hAAA) seen1 = 1'b1;
        else begin
          n0++;
          if (n0 <= TB_MAX_LOCK - 1) check("t3_grant_locked", 64'(grant), 64'(2'b01));
        end
      end
      if (!seen1) begin
        req_cmd_en = {1'b0, ~req_cmd_full[0]};
        req_cmd_addr0 = req_cmd_addr0 + 28'd1;
        step();
      end
    end
    check("t3_r1_served", 64'(seen1), 64'(1'b1));
    check("t3_lock_count", 64'(n0), 64'(4));
    idle_cycles(6);

    // backpressure: nothing issues while cmd_full, overflow is sticky
    do_reset();
    cmd_full = 1'b1;
    req_cmd_addr0 = 28'h40; req_cmd_addr1 = 28'h41;
    req_cmd_en = 2'b11;
    step();
    req_cmd_en = 2'b00;
    step();
    req_cmd_en = 2'b01;
    step();
    req_cmd_en = 2'b00;
    check("t4_overflow", 64'(req_overflow), 64'(2'b01));
    check("t4_held", 64'(req_cmd_full), 64'(2'b11));
    for (int c = 0; c < 7; c++) begin
      check("t4_stalled", 64'(cmd_en), 64'(1'b0));
      step();
    end
    cmd_full = 1'b0;
    nb = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (cmd_en) begin
        if (nb == 0) check("t4_first_r1", 64'(cmd_word_addr), 64'(28'h41));
        nb++;
      end
    end
    check("t4_both_issued", 64'(nb), 64'(2));
    check("t4_overflow_sticky", 64'(req_overflow), 64'(2'b01));

`ifdef DDR3_ARB_REFRESH_EN
    // refresh preempts a locked streaming requester, lock resumes afterwards
    do_reset();
    req_lock = 2'b01;
    req_cmd_instr0 = 3'b010; req_cmd_bl0 = 6'd3; req_cmd_addr0 = 28'h200;
    ref_at = -1; n0 = 0;
    for (int c = 1; c <= 250 && n0 == 0; c++) begin
      req_cmd_en = {1'b0, ~req_cmd_full[0]};
      req_cmd_addr0 = req_cmd_addr0 + 28'd1;
      step();
      if (cmd_en && cmd_instr == 3'b100) begin
        ref_at = c;
        check("t5_ref_bl", 64'(cmd_bl), 64'(6'd0));
        check("t5_ref_addr", 64'(cmd_word_addr), 64'(28'd0));
      end else if (cmd_en && ref_at >= 0 && grant == 2'b01) n0++;
    end
    check("t5_refresh_timing", 64'(ref_at >= 98 && ref_at <= 106), 64'(1'b1));
    check("t5_lock_resumes", 64'(n0 >= 1), 64'(1'b1));
    idle_cycles(6);
`endif

    // reset mid-lock discards the pending command
    do_reset();
    req_lock = 2'b01;
    req_cmd_addr0 = 28'h77;
    req_cmd_en = 2'b01;
    step();
    req_cmd_en = 2'b00;
    step();
    req_cmd_addr0 = 28'h78;
    req_cmd_en = 2'b01;
    step();
    req_cmd_en = 2'b00;
    check("t6_pending", 64'(req_cmd_full), 64'(2'b01));
    check("t6_locked", 64'(grant), 64'(2'b01));
    rst = 1'b0;
    step();
    rst = 1'b1;
    req_lock = 2'b00;
    check("t6_rst_en", 64'(cmd_en), 64'(1'b0));
    check("t6_rst_fields", 64'({cmd_instr, cmd_bl, cmd_word_addr}), 64'(0));
    check("t6_rst_full", 64'(req_cmd_full), 64'(2'b00));
    check("t6_rst_grant", 64'(grant), 64'(2'b00));
    nb = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (cmd_en) nb++;
    end
    check("t6_never_issued", 64'(nb), 64'(0));

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) != 0);
      req_cmd_en = {($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)};
      req_cmd_instr0 = 3'($urandom_range(0, 7));
      req_cmd_instr1 = 3'($urandom_range(0, 7));
      req_cmd_bl0 = 6'($urandom_range(0, 63));
      req_cmd_bl1 = 6'($urandom_range(0, 63));
      req_cmd_addr0 = 28'($urandom);
      req_cmd_addr1 = 28'($urandom);
      if ($urandom_range(0, 7) == 0) req_lock = 2'($urandom_range(0, 3));
      cmd_full = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b1;
    idle_cycles(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
